// File: rtl/ov7670_cfg_pkg.sv
// rtl/ov7670_cfg_pkg.sv - shared types and ROM marker words for the OV7670 config sequencer
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE
  } state_t;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

endpackage

// File: rtl/ov7670_config_ctrl_wait_timer.sv
// rtl/ov7670_config_ctrl_wait_timer.sv - cycle timer shared by the ack-timeout and delay waits
module cfg_wait_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_tc,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Expires on the i_tc-th cycle after load drops, so the owner spends exactly i_tc cycles waiting.
  assign o_expired = ((r_cnt + WIDTH'(1)) >= i_tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ov7670_config_ctrl.sv
// rtl/ov7670_config_ctrl.sv - walks the config ROM and issues SCCB register writes and delays
module ov7670_config_ctrl
  import ov7670_cfg_pkg::*;
#(
  parameter int CLK_FREQ    = 25000000,
  parameter int DELAY_MS    = 10,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_val,
  input  logic        sccb_done,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
  localparam int TMAX         = (DELAY_CYCLES > ACK_TIMEOUT) ? DELAY_CYCLES : ACK_TIMEOUT;
  localparam int TW           = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TC_DELAY = TW'(DELAY_CYCLES);
  localparam logic [TW-1:0] TC_ACK   = TW'(ACK_TIMEOUT);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_rom_addr;
  logic [7:0]    r_cmd_reg;
  logic [7:0]    r_cmd_val;
  logic          r_err;
  logic          w_accept;
  logic          w_is_cmd;
  logic          w_advance;
  logic          w_last;
  logic          w_expired;
  logic          w_tmr_load;
  logic [TW-1:0] w_tc;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_cmd   = (rom_data != END_MARK) && (rom_data != DELAY_MARK);
  assign w_last     = (r_rom_addr == 8'hFF);
  assign w_tmr_load = (r_state != S_WAIT_ACK) && (r_state != S_DELAY);
  assign w_tc       = (r_state == S_DELAY) ? TC_DELAY : TC_ACK;
  assign w_advance  = ((r_state == S_WAIT_ACK) && (sccb_done || w_expired)) ||
                      ((r_state == S_DELAY) && w_expired);

  cfg_wait_timer #(.WIDTH(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_tc      (w_tc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_MARK)        w_next = S_DONE;
        else if (rom_data == DELAY_MARK) w_next = S_DELAY;
        else                             w_next = S_SEND;
      end
      S_SEND:         if (cmd_ready) w_next = S_WAIT_ACK;
      S_WAIT_ACK, S_DELAY: begin
        if (w_advance) w_next = w_last ? S_DONE : S_FETCH;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_FETCH, S_DECODE, S_WAIT_ACK, S_DELAY: busy = 1'b1;
      S_SEND: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // A timed-out write is not retried; the error is only recorded and the walk moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= 8'd0;
      r_cmd_reg  <= 8'd0;
      r_cmd_val  <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rom_addr <= 8'd0;
        r_err      <= 1'b0;
      end else if (w_advance && !w_last) begin
        r_rom_addr <= r_rom_addr + 8'd1;
      end
      if ((r_state == S_DECODE) && w_is_cmd) begin
        r_cmd_reg <= rom_data[15:8];
        r_cmd_val <= rom_data[7:0];
      end
      if ((r_state == S_WAIT_ACK) && w_expired && !sccb_done) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign cmd_reg  = r_cmd_reg;
  assign cmd_val  = r_cmd_val;
  assign err      = r_err;

endmodule

// File: doc/ov7670_config_ctrl.md
OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, clock frequency in Hz.
REQ-002 SHALL have parameter DELAY_MS, default 10, length of the delay-marker wait in ms.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 65535, max cycles from command transfer to sccb_done.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to run the ROM sequence from entry 0.
REQ-007 SHALL have port rom_addr  out  8  config ROM address.
REQ-008 SHALL have port rom_data  in  16  ROM word {reg[15:8], value[7:0]}, registered ROM, valid 1 cycle after rom_addr.
REQ-009 SHALL have port cmd_valid  out  1  SCCB write command valid.
REQ-010 SHALL have port cmd_ready  in  1  SCCB master can accept a command.
REQ-011 SHALL have port cmd_reg  out  8  register address for the SCCB write.
REQ-012 SHALL have port cmd_val  out  8  data byte for the SCCB write.
REQ-013 SHALL have port sccb_done  in  1  one-cycle pulse: SCCB write finished.
REQ-014 SHALL have port busy  out  1  high from accepted start until DONE is reached.
REQ-015 SHALL have port done  out  1  level, high in DONE until the next accepted start.
REQ-016 SHALL have port err  out  1  sticky: an ACK_TIMEOUT expiry occurred in the current run.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, DONE.
REQ-018 IDLE/DONE: on start=1, clear rom_addr to 0, clear err and done, go to FETCH. start in any other state SHALL be ignored.
REQ-019 FETCH SHALL last exactly one cycle, covering ROM latency, then go to DECODE.
REQ-020 DECODE SHALL sample rom_data: 16'hFFFF -> DONE; 16'hFFF0 -> DELAY; any other value -> latch cmd_reg/cmd_val and go to SEND.
REQ-021 SEND SHALL hold cmd_valid=1 with stable cmd_reg/cmd_val until a cycle with cmd_ready=1; that cycle is the transfer, and cmd_valid SHALL be 0 the next cycle; then go to WAIT_ACK.
REQ-022 WAIT_ACK SHALL count cycles from 0; sccb_done=1 -> advance; count reaching ACK_TIMEOUT -> set err and advance. The entry is not retried.
REQ-023 sccb_done SHALL be ignored outside WAIT_ACK.
REQ-024 DELAY SHALL wait exactly CLK_FREQ/1000*DELAY_MS cycles, then advance.
REQ-025 "Advance" SHALL mean: if rom_addr==255, go to DONE with no wrap; otherwise increment rom_addr and go to FETCH.
REQ-026 Counter widths SHALL be $clog2 of the respective maximum plus 1; no overflow is permitted.
REQ-027 busy SHALL be 1 in FETCH, DECODE, SEND, WAIT_ACK and DELAY, and 0 in IDLE and DONE.
REQ-028 Latency without delays SHALL be per entry: 1 FETCH + 1 DECODE + SEND cycles + WAIT_ACK cycles.

Reset
REQ-029 On rst_n=0, the state SHALL be IDLE and rom_addr, cmd_valid, cmd_reg, cmd_val, busy, done, err SHALL all be 0, immediately and regardless of clk.
REQ-030 Reset mid-run SHALL drop cmd_valid at once; after release, no command SHALL be issued until a new start.

Structure
REQ-031 The shared package ov7670_cfg_pkg SHALL hold the state enum typedef, END_MARK=16'hFFFF and DELAY_MARK=16'hFFF0.
REQ-032 One sub-module, cfg_wait_timer (load, terminal count, expired flag), SHALL be shared by the WAIT_ACK and DELAY counting.

Verification
REQ-033 ROM {0:1280, 1:FFFF}, cmd_ready=1, sccb_done 3 cycles after transfer -> exactly one transfer with reg=12, val=80, then done=1, err=0.
REQ-034 ROM {0:FFF0, 1:FFFF}, CLK_FREQ=1000, DELAY_MS=5 -> no cmd_valid, exactly 5 DELAY cycles, then done=1.
REQ-035 cmd_ready held 0 for 7 cycles -> cmd_valid high for 8 cycles with cmd_reg/cmd_val stable, and one transfer.
REQ-036 ACK_TIMEOUT=10, sccb_done never -> err=1 after 10 WAIT_ACK cycles and rom_addr advances; a subsequent start clears err.
REQ-037 ROM all 0000, no FFFF -> 256 transfers, then done=1 with rom_addr=255 and no wrap.
REQ-038 rst_n=0 during SEND of entry 5 -> outputs are 0 asynchronously; after release with no start, no cmd_valid for 100 cycles.
